// File: rtl/mem_copy_dma_pkg.sv
// mem_copy_dma_pkg: shared state encoding and word size for the copy engine
package mem_copy_dma_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-by-word memory copy engine, one read then one write per word
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic             done
);
  state_t           state, state_d;
  logic [31:0]      src_ptr, dst_ptr;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = cnt == CNT_W'(1);
  assign busy = state != IDLE;
  assign done = state == FIN;

  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_d;

  // next state: a zero-length request goes straight to FIN without touching memory
  always_comb begin
    state_d = state == IDLE ? (start ? (count == '0 ? FIN : RD) : IDLE)
            : state == RD   ? WR
            : state == WR   ? (last ? FIN : RD)
            :                 IDLE;
  end

  // pointers, count and bus registers; the bus is set up one edge ahead so every output is registered
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (start && count != '0) begin
          src_ptr  <= src_addr & ~(WORD_BYTES - 32'd1);
          dst_ptr  <= dst_addr & ~(WORD_BYTES - 32'd1);
          cnt      <= count;
          mem_addr <= src_addr & ~(WORD_BYTES - 32'd1);
        end
        RD: begin
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_ptr;
          mem_we    <= 1'b1;
        end
        WR: begin
          src_ptr <= src_ptr + WORD_BYTES;
          dst_ptr <= dst_ptr + WORD_BYTES;
          cnt     <= cnt - CNT_W'(1);
          mem_we  <= 1'b0;
          if (!last) mem_addr <= src_ptr + WORD_BYTES;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: randomized and directed copies checked against a sequential copy model
module tb_mem_copy_dma;
  localparam int CNT_W = 6;
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0, dst_addr = '0;
  logic [CNT_W-1:0] count = '0;
  logic             mem_we, busy, done;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [31:0]      mem [0:255];
  logic [31:0]      ref_mem [0:255];
  logic [63:0]      wr_log[$];
  logic [31:0]      rd_log[$];
  int               n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  mem_copy_dma #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (busy && !done && !mem_we) rd_log.push_back(mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_copy(input logic [31:0] sa, input logic [31:0] da, input int n, input bit repulse);
    logic [63:0] exp_w[$];
    logic [31:0] s, d, a, b;
    int k, busy_cyc, done_at, bad, lat;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    s = {sa[31:2], 2'b00};
    d = {da[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      a = s + 32'(4 * i);
      b = d + 32'(4 * i);
      exp_w.push_back({b, ref_mem[a[9:2]]});
      ref_mem[b[9:2]] = ref_mem[a[9:2]];
    end
    wr_log.delete();
    rd_log.delete();
    @(negedge clock);
    start = 1'b1; src_addr = sa; dst_addr = da; count = CNT_W'(n);
    @(negedge clock);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; count = CNT_W'($urandom);
    k = 0; busy_cyc = 0; done_at = 0;
    while (done_at == 0 && k < 200) begin
      k++;
      if (k > 1) @(negedge clock);
      busy_cyc += int'(busy);
      if (done) done_at = k;
      start = repulse && k == 2;
      if (start) begin src_addr = 32'h100; dst_addr = 32'h180; count = CNT_W'(5); end
    end
    start = 1'b0;
    lat = n == 0 ? 1 : 2 * n + 1;
    check("done_lat", 64'(done_at), 64'(lat));
    check("busy_cyc", 64'(busy_cyc), 64'(lat));
    check("we_fin", 64'(mem_we), 64'd0);
    @(negedge clock);
    check("idle_after", {busy, done}, 64'd0);
    check("n_wr", 64'(wr_log.size()), 64'(n));
    for (int i = 0; i < exp_w.size(); i++)
      check("wr", i < wr_log.size() ? wr_log[i] : 64'hx, exp_w[i]);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", 64'(bad), 64'd0);
  endtask

  task automatic reset_mid_op();
    logic [31:0] w1, w3, w4;
    int t, dn;
    for (int i = 0; i < 4; i++) mem[(32'h100 >> 2) + i] = $urandom;
    w1 = mem[32'h100 >> 2];
    w3 = mem[(32'h208 >> 2)];
    w4 = mem[(32'h20C >> 2)];
    wr_log.delete();
    @(negedge clock);
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; count = CNT_W'(4);
    @(negedge clock);
    start = 1'b0;
    t = 0;
    while (!(mem_we && wr_log.size() == 1) && t < 50) begin
      @(negedge clock);
      t++;
    end
    check("rst_reach_wr2", 64'(t < 50), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_we_drop", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clock);
      dn += int'(done);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      dn += int'(done);
    end
    check("rst_no_done", 64'(dn), 64'd0);
    check("rst_word1", mem[32'h200 >> 2], w1);
    check("rst_word3", mem[32'h208 >> 2], w3);
    check("rst_word4", mem[32'h20C >> 2], w4);
    check("rst_n_wr", 64'(wr_log.size()), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #1;
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_busy_done", {busy, done}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    mem[0] = 32'hDEADBEEF;
    run_copy(32'h0, 32'h40, 1, 1'b0);
    check("single_wr", wr_log[0], {32'h40, 32'hDEADBEEF});

    for (int i = 0; i < 4; i++) mem[4 + i] = 32'(i + 1);
    run_copy(32'h10, 32'h30, 4, 1'b0);
    check("block_last", wr_log[3], {32'h3C, 32'h4});

    run_copy(32'h20, 32'h50, 0, 1'b0);

    run_copy(32'h13, 32'h60, 3, 1'b1);
    check("rd_n", 64'(rd_log.size()), 64'd3);
    check("rd0", rd_log[0], 64'h10);
    check("rd1", rd_log[1], 64'h14);
    check("rd2", rd_log[2], 64'h18);

    mem[32'h44 >> 2] = 32'h3FF;
    run_copy(32'h44, 32'h80, 1, 1'b0);
    check("io_bit7", 64'(wr_log[0][39]), 64'd1);
    check("io_data", 64'(wr_log[0][31:0]), 64'h3FF);

    reset_mid_op();

    for (int r = 0; r < 20; r++)
      run_copy(32'($urandom_range(0, 240 * 4 + 3)), 32'($urandom_range(0, 240 * 4 + 3)),
               $urandom_range(0, 12), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter CNT_W, default 6, the width of the word-count input (max transfer 2^CNT_W-1 words).
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 SHALL have port src_addr, input, 32, the byte address of the first source word.
REQ-006 SHALL have port dst_addr, input, 32, the byte address of the first destination word.
REQ-007 SHALL have port count, input, CNT_W, the number of 32-bit words to copy.
REQ-008 SHALL have port mem_we, output, 1, the write enable to the data-memory/IO responder.
REQ-009 SHALL have port mem_addr, output, 32, the byte address to the responder.
REQ-010 SHALL have port mem_wdata, output, 32, the write data to the responder's datain.
REQ-011 SHALL have port mem_rdata, input, 32, the responder's dataout.
REQ-012 SHALL have port busy, output, 1, high from the cycle after accepted start until the return to IDLE.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse on completion.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, FIN.
REQ-015 IDLE: on start=1 with count!=0, SHALL latch src_addr, dst_addr and count, then go to RD.
REQ-016 IDLE: on start=1 with count==0, SHALL go directly to FIN; no memory access is made.
REQ-017 RD: SHALL drive mem_addr=src pointer and mem_we=0 for one cycle.
REQ-018 RD: SHALL capture mem_rdata into a data register at the closing rising edge, then go to WR.
REQ-019 WR: SHALL drive mem_addr=dst pointer, mem_wdata=data register and mem_we=1 for exactly one cycle.
REQ-020 WR: at the closing edge SHALL advance both pointers by 4 and decrement the remaining count.
REQ-021 WR: SHALL go to FIN if the remaining count becomes 0; otherwise SHALL go to RD.
REQ-022 FIN: SHALL assert done=1 for one cycle, then go to IDLE.
REQ-023 Each word SHALL take exactly 2 cycles; a copy of N>0 words SHALL occupy busy for 2N+1 cycles.
REQ-024 Latched addresses SHALL have bits [1:0] forced to 0; pointer increments SHALL wrap modulo 2^32.
REQ-025 mem_addr bit 7 SHALL pass through unmodified, so copies may target or source IO space; no range checking is performed.
REQ-026 start SHALL be ignored while busy=1; input changes after acceptance SHALL have no effect.
REQ-027 In IDLE and FIN, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.
REQ-028 mem_we SHALL be a registered output; it SHALL never be 1 outside WR.

Reset
REQ-029 Reset SHALL force the following: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, pointers=0, count register=0.
REQ-030 Reset asserted mid-transfer SHALL abort immediately with no further write; a partial copy is left as is.

Structure
REQ-031 Package mem_copy_dma_pkg SHALL hold the state enumeration and the constant WORD_BYTES=4.
REQ-032 The block SHALL be a single module with no sub-modules; the FSM, pointers and data register are inline.

Verification
REQ-033 Single word: src=0x00, dst=0x40, count=1, mem[0]=0xDEADBEEF -> the following are required:
  - one write with mem_addr=0x40 and mem_wdata=0xDEADBEEF;
  - done exactly 3 cycles after start.
REQ-034 Block copy: src=0x10, dst=0x30, count=4, mem[0x10..0x1C]=1,2,3,4 -> the following are required:
  - writes to 0x30,0x34,0x38,0x3C in order with data 1..4;
  - busy high for 9 cycles.
REQ-035 Zero count: count=0 -> the following are required:
  - no mem_we pulse;
  - done asserted the cycle after start.
REQ-036 Busy and alignment checks:
  - start re-pulsed during a count=3 copy, and src=0x13 -> the second start is ignored and reads occur at 0x10,0x14,0x18.
REQ-037 Reset mid-op: reset asserted in the WR cycle of word 2 of 4 -> the following are required:
  - mem_we drops immediately;
  - destination words 3..4 are unchanged;
  - no done pulse.
REQ-038 IO target: dst=0x80, count=1, src word=0x000003FF -> a write with mem_addr[7]=1 and data 0x3FF is issued to the IO side.
